fft_frame_feeder: RTL

Synthesisable multi-channel sample source that replaces the counter-and-memory stimulus loop in front of the radix-4 FFT core. It holds CHANNELS frames of FRAME_LEN time-domain samples and streams them into the core's time_din/ld_n load port, backing off while the core reports busy. It supports single-frame, N-frame round-robin and continuous modes, so one block serves bring-up, regression and throughput runs.

---
 rtl/fft_frame_feeder_pkg.sv | 25 ++
 rtl/fft_frame_feeder_sample_ram.sv | 31 +++
 rtl/fft_frame_feeder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_pkg.sv
// Shared definitions for the FFT frame feeder: default geometry, run-mode
// encodings and the controller state encoding.
package fft_frame_feeder_pkg;

  localparam int DEF_DATA_W    = 17;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_FCNT_W    = 8;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NFRAME = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_t;

  // The unused encoding 3 behaves exactly like single-frame mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/fft_frame_feeder_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module feeder_sample_ram #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array; deliberately not reset so frames survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads so the output stays stable.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Multi-channel frame source for the radix-4 FFT load port. Streams stored
// frames as single, N-frame round-robin or continuous runs, stalling on busy.
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int FCNT_W    = DEF_FCNT_W,
  localparam int IDX_W    = $clog2(FRAME_LEN),
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W   = CH_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [FCNT_W-1:0] frame_num,
  input  logic              stop,
  input  logic              fft_busy,
  output logic [DATA_W-1:0] time_din,
  output logic              ld_n,
  output logic [CH_W-1:0]   dout_ch,
  output logic              sof,
  output logic              eof,
  output logic              active,
  output logic              done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ch_next;
  logic [IDX_W-1:0]  idx_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [FCNT_W-1:0] frame_num_q;
  logic              stop_q;
  logic [1:0]        mode_in;
  logic              issue;
  logic              start_run;
  logic              run_end;
  logic              done_d;

  assign mode_in = norm_mode(mode);
  assign ch_next = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
  assign active  = (state_q != ST_IDLE);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, read issue and end-of-run decision; the run ends on the
  // issue of the last index of the final frame so done lines up with eof.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    start_run = 1'b0;
    run_end   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_run = 1'b1;
          if (mode_in == MODE_NFRAME && frame_num == '0) state_d = ST_FIN;
          else                                           state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!fft_busy) begin
          issue = 1'b1;
          if (idx_q == IDX_LAST) begin
            case (mode_q)
              MODE_NFRAME: run_end = (frame_cnt_q == frame_num_q - FCNT_W'(1));
              MODE_CONT:   run_end = stop_q | stop;
              default:     run_end = 1'b1;
            endcase
            if (run_end) begin
              state_d = ST_FIN;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = (mode_q == MODE_NFRAME) && (frame_num_q == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration, sticky stop, sample index, frame count and channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_SINGLE;
      frame_num_q <= '0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      ch_q        <= '0;
      stop_q      <= 1'b0;
    end else begin
      if (start_run) begin
        mode_q      <= mode_in;
        frame_num_q <= frame_num;
        frame_cnt_q <= '0;
        idx_q       <= '0;
        stop_q      <= 1'b0;
        ch_q        <= (mode_in == MODE_SINGLE) ? ch_sel : '0;
      end
      if (state_q == ST_STREAM && mode_q == MODE_CONT && stop) stop_q <= 1'b1;
      if (issue) begin
        idx_q <= idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
          if (mode_q != MODE_SINGLE) ch_q <= ch_next;
        end
      end
    end
  end

  // Sideband outputs delayed one cycle to line up with the RAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_n    <= 1'b1;
      dout_ch <= '0;
      sof     <= 1'b0;
      eof     <= 1'b0;
      done    <= 1'b0;
    end else begin
      ld_n <= ~issue;
      sof  <= issue && (idx_q == '0);
      eof  <= issue && (idx_q == IDX_LAST);
      done <= done_d;
      if (issue) dout_ch <= ch_q;
    end
  end

  feeder_sample_ram #(
    .WIDTH (DATA_W),
    .DEPTH (CHANNELS * FRAME_LEN)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr ({ch_q, idx_q}),
    .rd_data (time_din)
  );

endmodule
